// File: rtl/data_mem_responder_if.sv
// CPU data-bus bundle: word address, store data, store strobe and load data.
interface data_mem_responder_if;
    logic [15:0] address;
    logic [15:0] out;
    logic        write;
    logic [15:0] in;

    modport master (output address, output out, output write, input in);
    modport slave  (input address, input out, input write, output in);
endinterface

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus keyboard latch, LED register and
// free-running timer mapped into the CPU's 16-bit word address space.
module data_mem_responder #(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] IO_BASE = 16'h6000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    input  logic [15:0]          kbd_data,
    input  logic                 kbd_valid,
    output logic                 kbd_ready,
    output logic [15:0]          led_out,
    output logic                 timer_wrap
);

    localparam logic [16:0] RAM_WORDS = 17'd1 << RAM_AW;

    logic [15:0] ram_r [RAM_WORDS];
    logic        full_r;
    logic [15:0] key_r;
    logic [15:0] led_r;
    logic [15:0] count_r;
    logic        en_r;
    logic        wrap_r;

    logic        ram_hit_s;
    logic        wr_kstat_s;
    logic        wr_led_s;
    logic        wr_timer_s;
    logic        wr_tctrl_s;
    logic        accept_s;
    logic        wrap_ev_s;
    logic [15:0] rd_s;

    assign ram_hit_s  = ({1'b0, bus.address} < RAM_WORDS);
    assign wr_kstat_s = bus.write && (bus.address == IO_BASE + 16'd1);
    assign wr_led_s   = bus.write && (bus.address == IO_BASE + 16'd2);
    assign wr_timer_s = bus.write && (bus.address == IO_BASE + 16'd3);
    assign wr_tctrl_s = bus.write && (bus.address == IO_BASE + 16'd4);
    assign accept_s   = kbd_valid && !full_r;
    // A wrap only counts when the increment really happens (a TIMER store overrides it).
    assign wrap_ev_s  = en_r && !wr_timer_s && (count_r == 16'hFFFF);

    // RAM store port; reset blocks stores but never clears contents.
    always_ff @(posedge clk) begin
        if (!reset && bus.write && ram_hit_s) begin
            ram_r[bus.address[RAM_AW-1:0]] <= bus.out;
        end
    end

    // I/O register state: keyboard latch, LED port, timer and its control.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r  <= 1'b0;
            key_r   <= 16'h0000;
            led_r   <= 16'h0000;
            count_r <= 16'h0000;
            en_r    <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            // A newly accepted key takes priority so it can never be dropped.
            if (accept_s) begin
                key_r  <= kbd_data;
                full_r <= 1'b1;
            end else if (wr_kstat_s) begin
                full_r <= 1'b0;
            end
            if (wr_led_s) begin
                led_r <= bus.out;
            end
            if (wr_timer_s) begin
                count_r <= bus.out;
            end else if (en_r) begin
                count_r <= count_r + 16'd1;
            end
            if (wr_tctrl_s) begin
                en_r <= bus.out[0];
            end
            wrap_r <= wrap_ev_s || (wrap_r && !(wr_tctrl_s && bus.out[1]));
        end
    end

    // Combinational load path so the CPU sees data in the same cycle.
    always_comb begin
        rd_s = 16'h0000;
        if (ram_hit_s) begin
            rd_s = ram_r[bus.address[RAM_AW-1:0]];
        end else begin
            case (bus.address)
                IO_BASE:         rd_s = key_r;
                IO_BASE + 16'd1: rd_s = {15'b0, full_r};
                IO_BASE + 16'd2: rd_s = led_r;
                IO_BASE + 16'd3: rd_s = count_r;
                IO_BASE + 16'd4: rd_s = {14'b0, wrap_r, en_r};
                default:         rd_s = 16'h0000;
            endcase
        end
    end

    assign bus.in     = rd_s;
    assign kbd_ready  = !full_r;
    assign led_out    = led_r;
    assign timer_wrap = wrap_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a behavioural model.
module tb_data_mem_responder;
    localparam int          RAM_AW = 14;
    localparam logic [15:0] IO     = 16'h6000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [15:0] led_out;
    logic        timer_wrap;

    int checks   = 0;
    int failures = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(.RAM_AW(RAM_AW), .IO_BASE(IO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .kbd_data   (kbd_data),
        .kbd_valid  (kbd_valid),
        .kbd_ready  (kbd_ready),
        .led_out    (led_out),
        .timer_wrap (timer_wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model of the memory map
    logic [15:0] m_ram [int];
    bit          m_full;
    logic [15:0] m_key;
    logic [15:0] m_led;
    int          m_count;
    bit          m_en;
    bit          m_wrap;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (ai < (1 << RAM_AW)) return m_ram.exists(ai) ? m_ram[ai] : 16'h0000;
        if (a == IO)           return m_key;
        if (a == IO + 16'd1)   return m_full ? 16'h0001 : 16'h0000;
        if (a == IO + 16'd2)   return m_led;
        if (a == IO + 16'd3)   return 16'(m_count);
        if (a == IO + 16'd4)   return 16'(2 * int'(m_wrap) + int'(m_en));
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
        bus.address = a;
        bus.out     = d;
        bus.write   = w;
        #1;
    endtask

    // Advance one clock, moving the model by the rules of the memory map.
    task automatic step();
        logic [15:0] a, d;
        bit w, accept, pop, wrapped;
        int nc;
        a = bus.address; d = bus.out; w = bus.write;
        @(posedge clk);
        if (reset) begin
            m_full = 0; m_key = 16'h0; m_led = 16'h0; m_count = 0; m_en = 0; m_wrap = 0;
        end else begin
            accept  = kbd_valid && !m_full;
            pop     = w && (a == IO + 16'd1);
            wrapped = 0;
            if (accept) begin m_key = kbd_data; m_full = 1; end
            else if (pop) m_full = 0;
            if (w && a == IO + 16'd2) m_led = d;
            if (w && a == IO + 16'd3) nc = int'(d);
            else if (m_en) begin
                nc = m_count + 1;
                if (nc == 65536) begin nc = 0; wrapped = 1; end
            end else nc = m_count;
            m_count = nc;
            if (w && a == IO + 16'd4) begin
                if (d[1]) m_wrap = 0;
                m_en = d[0];
            end
            if (wrapped) m_wrap = 1;
            if (w && int'(a) < (1 << RAM_AW)) m_ram[int'(a)] = d;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_in"}, bus.in, model_read(bus.address));
        chk({tag, "_ready"}, {15'b0, kbd_ready}, {15'b0, !m_full});
        chk({tag, "_led"}, led_out, m_led);
        chk({tag, "_wrap"}, {15'b0, timer_wrap}, {15'b0, m_wrap});
    endtask

    initial begin
        logic [15:0] ra, rd;
        int sel;
        reset = 1'b1; kbd_valid = 1'b0; kbd_data = 16'h0;
        drive(16'h7FFF, 16'h0, 1'b0);
        step(); step();
        reset = 1'b0;
        drive(IO + 16'd3, 16'h0, 1'b0);
        chk("rst_timer", bus.in, 16'h0000);
        chk("rst_ready", {15'b0, kbd_ready}, 16'h0001);
        chk("rst_led", led_out, 16'h0000);
        chk("rst_wrap", {15'b0, timer_wrap}, 16'h0000);

        // RAM store then load
        drive(16'h0010, 16'hBEEF, 1'b1); step();
        drive(16'h0010, 16'h0, 1'b0);
        chk("ram_rd", bus.in, 16'hBEEF);

        // Keyboard handshake and pop
        kbd_valid = 1'b1; kbd_data = 16'h0041;
        drive(16'h7FFF, 16'h0, 1'b0); step();
        kbd_data = 16'h0042;
        chk("kbd_ready_full", {15'b0, kbd_ready}, 16'h0000);
        drive(IO + 16'd1, 16'h0, 1'b0); chk("kbd_stat", bus.in, 16'h0001);
        drive(IO, 16'h0, 1'b0); step();
        chk("kbd_hold", bus.in, 16'h0041);
        drive(IO + 16'd1, 16'h5A5A, 1'b1); step();
        chk("kbd_pop_ready", {15'b0, kbd_ready}, 16'h0001);
        drive(IO, 16'h0, 1'b0); step();
        chk("kbd_second", bus.in, 16'h0042);
        chk("kbd_second_ready", {15'b0, kbd_ready}, 16'h0000);
        kbd_valid = 1'b0;
        drive(IO + 16'd1, 16'h0, 1'b1); step();
        drive(IO, 16'h0, 1'b0);
        chk("kbd_persist", bus.in, 16'h0042);

        // Timer wrap and sticky-flag clear
        drive(IO + 16'd3, 16'hFFFE, 1'b1); step();
        drive(IO + 16'd4, 16'h0001, 1'b1); step();
        drive(IO + 16'd3, 16'h0, 1'b0);
        chk("tmr_fffe", bus.in, 16'hFFFE);
        step(); chk("tmr_ffff", bus.in, 16'hFFFF);
        step(); chk("tmr_0000", bus.in, 16'h0000);
        chk("tmr_wrap_set", {15'b0, timer_wrap}, 16'h0001);
        drive(IO + 16'd4, 16'h0003, 1'b1);
        chk("tctrl_rd", bus.in, 16'h0003);
        step();
        drive(IO + 16'd4, 16'h0, 1'b0);
        chk("tmr_wrap_clr", {15'b0, timer_wrap}, 16'h0000);
        chk("tctrl_en", bus.in, 16'h0001);

        // Store overrides a counting increment
        drive(IO + 16'd3, 16'h1234, 1'b1); step();
        drive(IO + 16'd3, 16'h0, 1'b0);
        chk("tmr_load", bus.in, 16'h1234);
        step(); chk("tmr_inc", bus.in, 16'h1235);

        // Wrap and clear in the same cycle keep the flag
        drive(IO + 16'd3, 16'hFFFF, 1'b1); step();
        drive(IO + 16'd4, 16'h0003, 1'b1); step();
        chk("wrap_vs_clear", {15'b0, timer_wrap}, 16'h0001);

        // LED, unmapped reads, reset beating a store and a handshake
        drive(IO + 16'd2, 16'h00FF, 1'b1); step();
        chk("led_set", led_out, 16'h00FF);
        drive(16'h7FFF, 16'h0, 1'b0); chk("unmapped", bus.in, 16'h0000);
        drive(IO + 16'd5, 16'h0, 1'b0); chk("io_gap", bus.in, 16'h0000);
        reset = 1'b1; kbd_valid = 1'b1; kbd_data = 16'h7777;
        drive(IO + 16'd2, 16'h1234, 1'b1); step();
        reset = 1'b0; kbd_valid = 1'b0;
        drive(IO + 16'd3, 16'h0, 1'b0);
        chk("rst2_timer", bus.in, 16'h0000);
        chk("rst2_led", led_out, 16'h0000);
        chk("rst2_ready", {15'b0, kbd_ready}, 16'h0001);
        chk("rst2_wrap", {15'b0, timer_wrap}, 16'h0000);
        drive(IO, 16'h0, 1'b0); chk("rst2_key", bus.in, 16'h0000);

        // Seed a small RAM window so every random read has a known value
        for (int i = 0; i < 16; i++) begin
            drive(16'(i), 16'($urandom), 1'b1); step();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) == 0);
            kbd_valid = ($urandom_range(0, 2) == 0);
            kbd_data  = 16'($urandom);
            sel = $urandom_range(0, 7);
            if (sel < 2)       ra = 16'($urandom_range(0, 16));
            else if (sel == 7) ra = 16'h7FFF;
            else               ra = IO + 16'(sel - 2);
            rd = 16'($urandom);
            if (ra == IO + 16'd3 && rd[0]) rd = 16'hFFFF - 16'($urandom_range(0, 3));
            if (ra == IO + 16'd4 && $urandom_range(0, 3) != 0) rd[0] = 1'b1;
            drive(ra, rd, ($urandom_range(0, 2) == 0) && ra != 16'd16);
            check_all("rnd");
            step();
        end
        reset = 1'b0; kbd_valid = 1'b0;
        drive(IO + 16'd3, 16'h0, 1'b0);
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
